// File: rtl/neg_pipe.sv
// neg_pipe: elastic pipelined sign unit (NEG/ABS/NABS/PASS).
// Optional MAXPOS saturation, per-result flags, sticky overflow.
module neg_pipe #(
   parameter int WIDTH    = 32,
   parameter int STAGES   = 2,
   parameter int SATURATE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             out_sign,
   output logic             ovf_sticky,
   input  logic             ovf_clr
);

   localparam logic [WIDTH-1:0] MINNEG =
      {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAXPOS =
      {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] ONE =
      {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]  w_neg;
   logic [WIDTH-1:0]  w_raw;
   logic [WIDTH-1:0]  w_res;
   logic              w_ovf;
   logic              w_isneg;
   logic              w_ismin;
   logic [STAGES-1:0] w_load;
   logic              w_full;

   logic [STAGES-1:0] r_vld;
   logic [STAGES-1:0] r_ovf;
   logic [STAGES-1:0] r_zero;
   logic [STAGES-1:0] r_sign;
   logic [WIDTH-1:0]  r_data [STAGES];
   logic              r_sticky;

   assign w_neg   = ~in_data + ONE;
   assign w_isneg = in_data[WIDTH-1];
   assign w_ismin = (in_data == MINNEG);

   // Sign operation select; MINNEG negation is the only overflow.
   always_comb begin
      w_raw = in_data;
      w_ovf = 1'b0;
      unique case (in_mode)
         2'b00: begin
            w_raw = w_neg;
            w_ovf = w_ismin;
         end
         2'b01: begin
            w_raw = w_isneg ? w_neg : in_data;
            w_ovf = w_ismin;
         end
         2'b10: begin
            w_raw = w_isneg ? in_data : w_neg;
         end
         default: begin
            w_raw = in_data;
         end
      endcase
   end

   assign w_res = (w_ovf && (SATURATE != 0)) ? MAXPOS : w_raw;

   // Stage k loads when any stage from k onward has a hole,
   // or the consumer takes the last result this cycle.
   always_comb begin
      w_load = '0;
      w_full = 1'b1;
      for (int k = 0; k < STAGES; k++) begin
         w_full = 1'b1;
         for (int j = k; j < STAGES; j++) begin
            w_full = w_full & r_vld[j];
         end
         w_load[k] = out_ready || !w_full;
      end
   end

   assign in_ready = w_load[0];

   // Pipeline registers; payload only moves with a valid item.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= '0;
         r_ovf  <= '0;
         r_zero <= '0;
         r_sign <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_data[k] <= '0;
         end
      end else begin
         if (w_load[0]) begin
            r_vld[0] <= in_valid;
         end
         if (w_load[0] && in_valid) begin
            r_data[0] <= w_res;
            r_ovf[0]  <= w_ovf;
            r_zero[0] <= (w_res == '0);
            r_sign[0] <= w_res[WIDTH-1];
         end
         for (int k = 1; k < STAGES; k++) begin
            if (w_load[k]) begin
               r_vld[k] <= r_vld[k-1];
            end
            if (w_load[k] && r_vld[k-1]) begin
               r_data[k] <= r_data[k-1];
               r_ovf[k]  <= r_ovf[k-1];
               r_zero[k] <= r_zero[k-1];
               r_sign[k] <= r_sign[k-1];
            end
         end
      end
   end

   // Sticky overflow: a delivered overflow beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 1'b0;
      end else if (out_valid && out_ready && out_ovf) begin
         r_sticky <= 1'b1;
      end else if (ovf_clr) begin
         r_sticky <= 1'b0;
      end
   end

   assign out_valid  = r_vld[STAGES-1];
   assign out_data   = r_data[STAGES-1];
   assign out_ovf    = r_ovf[STAGES-1];
   assign out_zero   = r_zero[STAGES-1];
   assign out_sign   = r_sign[STAGES-1];
   assign ovf_sticky = r_sticky;

endmodule
